// File: rtl/switch_tx_pkg.sv
// -----------------------------------------------------------------------------
// switch_tx_pkg
// Shared types for the switch ingress packet transmitter:
//   tx_state_e : framing FSM states
//   tx_cmd_t   : packet command {da, len, seed} as stored in the command FIFO
//   CMD_W      : packed width of tx_cmd_t
// -----------------------------------------------------------------------------
package switch_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR_DA,
      HDR_LEN,
      PAYLOAD,
      GAP
   } tx_state_e;

   typedef struct packed {
      logic [7:0] da;
      logic [7:0] len;
      logic [7:0] seed;
   } tx_cmd_t;

   localparam int CMD_W = $bits(tx_cmd_t);

endpackage

// File: rtl/tx_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tx_cmd_fifo
// Synchronous FIFO holding packed tx_cmd_t packet commands.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (flushes the FIFO)
//   i_push/i_wdata : write request and command; ignored while full
//   i_pop          : read request; ignored while empty
//   o_rdata        : command at the head (show-ahead)
//   o_full/o_empty : registered-count status flags
//   o_count        : number of stored commands
// -----------------------------------------------------------------------------
module tx_cmd_fifo
   import switch_tx_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [CMD_W-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [CMD_W-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [CMD_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // Flags come from the registered count only, so ready never depends
   // combinationally on a same-cycle pop.
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rd_ptr];

   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop & ~o_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_wdata;
   end

endmodule

// File: rtl/switch_pkt_tx.sv
// -----------------------------------------------------------------------------
// switch_pkt_tx
// Ingress packet transmitter for the switch input port. Queues packet commands
// and serialises each as DA, LEN, then LEN payload bytes (seed, seed+1, ...),
// one byte per cycle, followed by MIN_GAP idle cycles.
// Ports:
//   fast_clk, reset_b    : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake; cmd_da/cmd_len/cmd_seed payload
//   data_stall           : switch refuses a new packet (checked between packets)
//   data_valid, data     : registered byte stream; data is 00 when not valid
//   busy                 : frame in progress or commands pending
//   cnt_clr              : synchronous clear of the statistics counters
//   pkt_cnt, stall_cnt   : saturating frame count / stalled-launch cycle count
// -----------------------------------------------------------------------------
module switch_pkt_tx
   import switch_tx_pkg::*;
#(
   parameter int CMD_DEPTH = 4,
   parameter int MIN_GAP   = 1,
   parameter int CNT_W     = 16
)(
   input  logic             fast_clk,
   input  logic             reset_b,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [7:0]       cmd_da,
   input  logic [7:0]       cmd_len,
   input  logic [7:0]       cmd_seed,
   input  logic             data_stall,
   output logic             data_valid,
   output logic [7:0]       data,
   output logic             busy,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] pkt_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int CW = $clog2(CMD_DEPTH) + 1;
   localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);

   tx_state_e        r_state;
   tx_state_e        w_next;
   logic [7:0]       r_len;
   logic [7:0]       r_seed;
   logic [7:0]       r_pay;
   logic [7:0]       r_rem;
   logic [GW-1:0]    r_gap;
   logic             r_dv;
   logic [7:0]       r_data;
   logic [CNT_W-1:0] r_pkt_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic [CMD_W-1:0] w_fifo_rdata;
   logic             w_fifo_full;
   logic             w_fifo_empty;
   logic [CW-1:0]    w_fifo_count;
   tx_cmd_t          w_head;
   logic             w_go;
   logic             w_launch;
   logic             w_gap_done;
   logic             w_dv_nxt;
   logic [7:0]       w_data_nxt;
   logic             w_last;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   tx_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
      .i_clk   (fast_clk),
      .i_rst_n (reset_b),
      .i_push  (cmd_valid),
      .i_wdata ({cmd_da, cmd_len, cmd_seed}),
      .i_pop   (w_launch),
      .o_rdata (w_fifo_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   assign w_head     = w_fifo_rdata;
   assign w_go       = ~w_fifo_empty & ~data_stall;
   assign w_gap_done = (r_gap == '0);
   assign w_launch   = (w_next == HDR_DA);

   assign cmd_ready  = ~w_fifo_full;
   assign busy       = (r_state != IDLE) || (w_fifo_count != '0);
   assign data_valid = r_dv;
   assign data       = r_data;
   assign pkt_cnt    = r_pkt_cnt;
   assign stall_cnt  = r_stall_cnt;

   // State register
   always_ff @(posedge fast_clk or negedge reset_b) begin
      if (!reset_b) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Next state. The state names the byte currently on the wire. The last GAP
   // cycle makes the launch decision itself, so exactly MIN_GAP idle cycles
   // separate back-to-back frames; otherwise the FSM rests in IDLE.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:    if (w_go) w_next = HDR_DA;
         HDR_DA:  w_next = HDR_LEN;
         HDR_LEN: w_next = (r_len != 8'd0) ? PAYLOAD : GAP;
         PAYLOAD: if (r_rem == 8'd0) w_next = GAP;
         GAP:     if (w_gap_done) w_next = w_go ? HDR_DA : IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Output decode: the byte to register for the coming state
   always_comb begin
      w_dv_nxt   = 1'b0;
      w_data_nxt = 8'h00;
      w_last     = 1'b0;
      unique case (w_next)
         HDR_DA: begin
            w_dv_nxt   = 1'b1;
            w_data_nxt = w_head.da;
         end
         HDR_LEN: begin
            w_dv_nxt   = 1'b1;
            w_data_nxt = r_len;
            w_last     = (r_len == 8'd0);
         end
         PAYLOAD: begin
            w_dv_nxt = 1'b1;
            if (r_state == HDR_LEN) begin
               w_data_nxt = r_seed;
               w_last     = (r_len == 8'd1);
            end else begin
               w_data_nxt = r_pay;
               w_last     = (r_rem == 8'd1);
            end
         end
         default: ;
      endcase
   end

   // Output registers and gap counter
   always_ff @(posedge fast_clk or negedge reset_b) begin
      if (!reset_b) begin
         r_dv   <= 1'b0;
         r_data <= 8'h00;
         r_gap  <= '0;
      end else begin
         r_dv   <= w_dv_nxt;
         r_data <= w_data_nxt;
         if (w_next == GAP && r_state != GAP) r_gap <= GAP_LOAD;
         else if (r_state == GAP && !w_gap_done) r_gap <= r_gap - 1'b1;
      end
   end

   // Working copy of the frame's command plus payload value / remaining count.
   // r_rem counts payload bytes still to send after the one on the wire.
   always_ff @(posedge fast_clk) begin
      if (w_launch) begin
         r_len  <= w_head.len;
         r_seed <= w_head.seed;
      end
      if (r_state == HDR_LEN) begin
         r_pay <= r_seed + 8'd1;
         r_rem <= r_len - 8'd1;
      end else if (r_state == PAYLOAD && r_rem != 8'd0) begin
         r_pay <= r_pay + 8'd1;
         r_rem <= r_rem - 8'd1;
      end
   end

   // Statistics; clear wins over a same-cycle increment
   always_ff @(posedge fast_clk or negedge reset_b) begin
      if (!reset_b) begin
         r_pkt_cnt   <= '0;
         r_stall_cnt <= '0;
      end else if (cnt_clr) begin
         r_pkt_cnt   <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_last) r_pkt_cnt <= sat_inc(r_pkt_cnt);
         if (r_state == IDLE && !w_fifo_empty && data_stall)
            r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

endmodule

// File: tb/tb_switch_pkt_tx.sv
module tb_switch_pkt_tx;

   logic        fast_clk = 1'b0;
   logic        reset_b = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_da = 8'h00;
   logic [7:0]  cmd_len = 8'h00;
   logic [7:0]  cmd_seed = 8'h00;
   logic        data_stall = 1'b0;
   logic        data_valid;
   logic [7:0]  data;
   logic        busy;
   logic        cnt_clr = 1'b0;
   logic [15:0] pkt_cnt;
   logic [15:0] stall_cnt;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic [7:0] b;
      bit         last;
      int         gap;     // required idle cycles before this first byte, -1 = any
   } exp_t;

   exp_t exp_q[$];
   bit   sb_en = 1'b1;
   int   idle_run = 0;
   bit   in_frame = 1'b0;

   logic [7:0] v4 [10] = '{8'h77, 8'h08, 8'hF0, 8'hF1, 8'hF2,
                           8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7};

   switch_pkt_tx #(.CMD_DEPTH(4), .MIN_GAP(1), .CNT_W(16)) dut (
      .fast_clk   (fast_clk),
      .reset_b    (reset_b),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_da     (cmd_da),
      .cmd_len    (cmd_len),
      .cmd_seed   (cmd_seed),
      .data_stall (data_stall),
      .data_valid (data_valid),
      .data       (data),
      .busy       (busy),
      .cnt_clr    (cnt_clr),
      .pkt_cnt    (pkt_cnt),
      .stall_cnt  (stall_cnt)
   );

   always #5 fast_clk = ~fast_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge fast_clk);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] b, input bit last, input int gap);
      exp_q.push_back('{b, last, gap});
   endtask

   task automatic push_cmd(input logic [7:0] da, input logic [7:0] len, input logic [7:0] seed);
      cmd_da    = da;
      cmd_len   = len;
      cmd_seed  = seed;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit done = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!busy && !data_valid && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      chk({nm, "_idle"}, 32'(done), 32'd1);
   endtask

   // Monitor: pops the scoreboard for every valid byte, checks frame
   // continuity, inter-frame gaps and the idle data value.
   always @(negedge fast_clk) begin
      if (reset_b && sb_en) begin
         if (data_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_byte: got %0h expected none", data);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (!in_frame && e.gap >= 0) chk("gap", 32'(idle_run), 32'(e.gap));
               chk("byte", 32'(data), 32'(e.b));
               in_frame = !e.last;
            end
            idle_run = 0;
         end else begin
            if (in_frame) begin
               total++;
               bad++;
               $display("FAIL bubble: got data_valid 0 expected 1");
               in_frame = 1'b0;
            end
            chk("idle_data", 32'(data), 32'h0);
            idle_run++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int  dv_seen;
      bit  found;

      // 1: reset state
      reset_b = 1'b0;
      repeat (3) @(posedge fast_clk);
      #1;
      chk("rst_dv",        32'(data_valid), 32'd0);
      chk("rst_data",      32'(data),       32'h0);
      chk("rst_ready",     32'(cmd_ready),  32'd1);
      chk("rst_busy",      32'(busy),       32'd0);
      chk("rst_pkt_cnt",   32'(pkt_cnt),    32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt),  32'd0);
      reset_b = 1'b1;
      tick();

      // 2: single frame, latency and packet count
      push_exp(8'h55, 1'b0, -1);
      push_exp(8'h03, 1'b0, -1);
      push_exp(8'h10, 1'b0, -1);
      push_exp(8'h11, 1'b0, -1);
      push_exp(8'h12, 1'b1, -1);
      push_cmd(8'h55, 8'h03, 8'h10);
      tick();
      chk("t2_lat_dv", 32'(data_valid), 32'd1);
      chk("t2_lat_da", 32'(data),       32'h55);
      wait_idle("t2");
      chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd1);

      // 3: stall held 20 cycles with one queued command
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      chk("t3_clr_pkt", 32'(pkt_cnt), 32'd0);
      data_stall = 1'b1;
      push_exp(8'h33, 1'b0, -1);
      push_exp(8'h01, 1'b0, -1);
      push_exp(8'h40, 1'b1, -1);
      push_cmd(8'h33, 8'h01, 8'h40);
      dv_seen = 0;
      repeat (20) begin
         tick();
         if (data_valid) dv_seen++;
      end
      chk("t3_no_dv_stalled", 32'(dv_seen), 32'd0);
      data_stall = 1'b0;
      tick();
      chk("t3_release_dv", 32'(data_valid), 32'd1);
      chk("t3_release_da", 32'(data),       32'h33);
      wait_idle("t3");
      chk("t3_stall_cnt", 32'(stall_cnt), 32'd20);
      chk("t3_pkt_cnt",   32'(pkt_cnt),   32'd1);

      // 4: stall raised mid-frame is ignored, next frame held back
      for (int i = 0; i < 10; i++) push_exp(v4[i], (i == 9), -1);
      push_exp(8'h78, 1'b0, -1);
      push_exp(8'h00, 1'b1, -1);
      push_cmd(8'h77, 8'h08, 8'hF0);
      push_cmd(8'h78, 8'h00, 8'h00);
      found = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (data_valid && data == 8'hF1) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("t4_reach_pay1", 32'(found), 32'd1);
      data_stall = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (!data_valid) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("t4_frame_end", 32'(found), 32'd1);
      chk("t4_queue_left", 32'(exp_q.size()), 32'd2);
      dv_seen = 0;
      repeat (10) begin
         tick();
         if (data_valid) dv_seen++;
      end
      chk("t4_next_held", 32'(dv_seen), 32'd0);
      chk("t4_busy_held", 32'(busy),    32'd1);
      data_stall = 1'b0;
      wait_idle("t4");

      // 5: back-to-back commands, exactly one idle cycle between frames
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      push_exp(8'hA0, 1'b0, -1);
      push_exp(8'h02, 1'b0, -1);
      push_exp(8'hFE, 1'b0, -1);
      push_exp(8'hFF, 1'b1, -1);
      push_exp(8'hA1, 1'b0, 1);
      push_exp(8'h00, 1'b1, -1);
      push_cmd(8'hA0, 8'h02, 8'hFE);
      push_cmd(8'hA1, 8'h00, 8'h00);
      wait_idle("t5");
      chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd2);

      // 6: FIFO full backpressure, then reset in the middle of a payload
      sb_en = 1'b0;
      data_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t6_ready_%0d", i), 32'(cmd_ready), (i < 4) ? 32'd1 : 32'd0);
         cmd_da    = 8'hC0 + 8'(i);
         cmd_len   = 8'h10;
         cmd_seed  = 8'h00;
         cmd_valid = 1'b1;
         tick();
      end
      cmd_valid = 1'b0;
      chk("t6_full_ready", 32'(cmd_ready), 32'd0);
      data_stall = 1'b0;
      tick();
      chk("t6_order_da", 32'(data), 32'hC0);
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (data_valid && data == 8'h03) begin
            found = 1'b1;
            break;
         end
         tick();
      end
      chk("t6_reach_payload", 32'(found), 32'd1);
      #2 reset_b = 1'b0;
      #1;
      chk("t6_rst_dv",    32'(data_valid), 32'd0);
      chk("t6_rst_data",  32'(data),       32'h0);
      chk("t6_rst_busy",  32'(busy),       32'd0);
      chk("t6_rst_ready", 32'(cmd_ready),  32'd1);
      chk("t6_rst_pkt",   32'(pkt_cnt),    32'd0);
      tick();
      reset_b = 1'b1;
      dv_seen = 0;
      repeat (6) begin
         tick();
         if (data_valid) dv_seen++;
      end
      chk("t6_flushed_dv",   32'(dv_seen), 32'd0);
      chk("t6_flushed_busy", 32'(busy),    32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
